pls_gen: RTL and testbench
==========================

PLS_GEN -- requirements
Module: pls_gen

Interface
REQ-001 SHALL have port: rst  input  1  asynchronous active-low reset.
REQ-002 SHALL have port: clk  input  1  single clock; all state on posedge clk.
REQ-003 SHALL have port: clr  input  1  asynchronous restart request; its rising edge restarts the generator.
REQ-004 SHALL have port: en  input  1  free-run enable; level, sampled directly.
REQ-005 SHALL have port: div  input  16  free-run period in clk cycles; values 0 and 1 are treated as 2.
REQ-006 SHALL have port: bst_req  input  1  asynchronous burst request; its rising edge starts a burst.
REQ-007 SHALL have port: bst_num  input  7  burst pulse count, 1..127; latched at burst start.
REQ-008 SHALL have port: plso  output  1  registered pulse output, feeding a pulse-counter plsi input.
REQ-009 SHALL have port: tick  output  1  registered one-cycle strobe at each free-run period wrap.
REQ-010 SHALL have port: bst_busy  output  1  registered; high while a burst is in progress.

Function
REQ-011 SHALL pass clr and bst_req each through a two-flop synchronizer (s0, s1); rising edge = s0 & ~s1.
REQ-012 SHALL implement FSM states RUN, B_HI, B_LO; RUN after reset.
REQ-013 SHALL hold a 16-bit counter cnt and a 16-bit latched divisor div_q; div_q loads max(div,2) in every RUN cycle where cnt==0.
REQ-014 SHALL, in RUN with en=1, advance cnt by 1 per clk and wrap to 0 when cnt==div_q-1.
REQ-015 SHALL, in RUN with en=1, register plso <= 1 when next cnt >= (div_q>>1), else 0; div_q=10 gives 5 cycles low, 5 high.
REQ-016 SHALL pulse tick high for exactly one cycle on the edge where cnt wraps to 0; tick=0 in all other cycles.
REQ-017 SHALL, in RUN with en=0, hold cnt and plso, with tick=0.
REQ-018 SHALL treat a div change as taking effect only at the next cnt==0, so no runt period occurs.
REQ-019 SHALL, on a clr rising edge, set cnt=0, plso=0, tick=0, bst_busy=0 and state=RUN at the next clk edge; this has top priority and aborts any burst.
REQ-020 SHALL, on a bst_req rising edge in RUN with bst_num!=0, latch n=bst_num, enter B_HI and set plso=1, bst_busy=1 at that edge (plso high on the 2nd clk edge after bst_req is first sampled high).
REQ-021 SHALL hold B_HI for 2 cycles with plso=1, then B_LO for 2 cycles with plso=0; each B_LO exit decrements n.
REQ-022 SHALL, at B_LO exit with n==1, return to RUN with cnt=0, plso=0 and bst_busy=0; a burst of n pulses occupies exactly 4n cycles.
REQ-023 SHALL ignore bst_req edges while bst_busy=1 and whenever bst_num==0.
REQ-024 SHALL run a burst independently of en, with cnt frozen and tick=0 throughout.
REQ-025 SHALL give clr priority over bst_req when both edges are detected in the same cycle: clr wins and no burst starts.

Reset
REQ-026 SHALL, while rst=0, force plso=0, tick=0, bst_busy=0, cnt=0, div_q=2, n=0, state=RUN and all synchronizer flops to 0, independent of clk.
REQ-027 SHALL produce no clr or bst_req edge from inputs that are already high when rst deasserts, until they go low and high again.

Configuration
REQ-028 SHALL compile in burst logic (B_HI/B_LO, n, bst_req synchronizer) only when macro PLS_GEN_BURST_EN is defined.
REQ-029 SHALL, without PLS_GEN_BURST_EN, ignore bst_req and bst_num, tie bst_busy to 0, and never leave state RUN; free-run and clr behaviour are unchanged.

Verification
REQ-030 SHALL cover free run: div=10, en=1 from reset -> plso period 10 clk (5 low/5 high), tick once every 10 clk.
REQ-031 SHALL cover div edge cases and mid-period change: div=0 and div=1 -> period 2; div changed 10->4 mid-period -> current 10-clk period completes, then 4-clk periods.
REQ-032 SHALL cover enable hold: en=0 for 7 clk at cnt=3 -> plso and cnt frozen, tick=0, and the sequence resumes from cnt=3.
REQ-033 SHALL cover a burst (PLS_GEN_BURST_EN): bst_num=3, bst_req pulse -> 3 plso pulses of 2 high/2 low, bst_busy high 12 clk, then RUN with cnt=0.
REQ-034 SHALL cover burst ignore and abort: a second bst_req mid-burst is ignored; a clr edge mid-burst -> plso=0 and bst_busy=0 at the next edge.
REQ-035 SHALL cover reset mid-burst and the macro-off build: rst low mid-burst -> all outputs 0 immediately; with the macro undefined, bst_req toggling has no effect and bst_busy stays 0.

Source files
------------

// File: rtl/pls_gen.sv
// pls_gen: divided free-running pulse generator with synchronized restart.
// Define PLS_GEN_BURST_EN to compile in the fixed-shape burst mode (2 high / 2 low per pulse).
module pls_gen (
  input  logic        rst,
  input  logic        clk,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] div,
  input  logic        bst_req,
  input  logic [6:0]  bst_num,
  output logic        plso,
  output logic        tick,
  output logic        bst_busy
);

`ifdef PLS_GEN_BURST_EN
  typedef enum logic [1:0] {RUN = 2'd0, B_HI = 2'd1, B_LO = 2'd2} state_t;
`else
  typedef enum logic [1:0] {RUN = 2'd0} state_t;
`endif

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [15:0] r_div_q;
  logic        r_plso;
  logic        r_tick;
  logic        r_clr_s0;
  logic        r_clr_s1;
  logic [1:0]  r_warm;

  state_t      w_state_next;
  logic [15:0] w_cnt_next;
  logic [15:0] w_div_q_next;
  logic        w_plso_next;
  logic        w_tick_next;

  logic [15:0] w_div_eff;
  logic [15:0] w_dq;
  logic        w_wrap;
  logic [15:0] w_cnt_inc;
  logic        w_clr_rise;

  // Edges are only trusted once s1 holds a genuine sample, so inputs already
  // high when reset lifts do not look like a fresh rising edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clr_s0 <= 1'b0;
      r_clr_s1 <= 1'b0;
      r_warm   <= 2'd0;
    end else begin
      r_clr_s0 <= clr;
      r_clr_s1 <= r_clr_s0;
      if (!r_warm[1]) r_warm <= r_warm + 2'd1;
    end
  end

  assign w_clr_rise = r_clr_s0 & ~r_clr_s1 & r_warm[1];

`ifdef PLS_GEN_BURST_EN
  logic       r_bst_s0;
  logic       r_bst_s1;
  logic [6:0] r_n;
  logic       r_ph;
  logic       r_busy;
  logic [6:0] w_n_next;
  logic       w_ph_next;
  logic       w_busy_next;
  logic       w_bst_rise;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bst_s0 <= 1'b0;
      r_bst_s1 <= 1'b0;
      r_n      <= 7'd0;
      r_ph     <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_bst_s0 <= bst_req;
      r_bst_s1 <= r_bst_s0;
      r_n      <= w_n_next;
      r_ph     <= w_ph_next;
      r_busy   <= w_busy_next;
    end
  end

  assign w_bst_rise = r_bst_s0 & ~r_bst_s1 & r_warm[1];
  assign bst_busy   = r_busy;
`else
  logic w_unused;
  assign w_unused = ^{bst_req, bst_num};
  assign bst_busy = 1'b0;
`endif

  // The divisor that governs this cycle: a new one is adopted only at cnt==0.
  assign w_div_eff = (div < 16'd2) ? 16'd2 : div;
  assign w_dq      = (r_state == RUN && r_cnt == 16'd0) ? w_div_eff : r_div_q;
  assign w_wrap    = (r_cnt >= w_dq - 16'd1);
  assign w_cnt_inc = w_wrap ? 16'd0 : r_cnt + 16'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RUN;
      r_cnt   <= 16'd0;
      r_div_q <= 16'd2;
      r_plso  <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_div_q <= w_div_q_next;
      r_plso  <= w_plso_next;
      r_tick  <= w_tick_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_div_q_next = r_div_q;
    w_plso_next  = r_plso;
    w_tick_next  = 1'b0;
`ifdef PLS_GEN_BURST_EN
    w_n_next     = r_n;
    w_ph_next    = r_ph;
    w_busy_next  = r_busy;
`endif
    if (r_state == RUN && r_cnt == 16'd0) w_div_q_next = w_div_eff;

    if (w_clr_rise) begin
      w_state_next = RUN;
      w_cnt_next   = 16'd0;
      w_plso_next  = 1'b0;
`ifdef PLS_GEN_BURST_EN
      w_ph_next    = 1'b0;
      w_busy_next  = 1'b0;
`endif
    end else begin
`ifdef PLS_GEN_BURST_EN
      case (r_state)
        RUN: begin
          if (w_bst_rise && bst_num != 7'd0) begin
            w_n_next     = bst_num;
            w_state_next = B_HI;
            w_ph_next    = 1'b0;
            w_plso_next  = 1'b1;
            w_busy_next  = 1'b1;
          end else if (en) begin
            w_cnt_next  = w_cnt_inc;
            w_plso_next = (w_cnt_inc >= (w_dq >> 1));
            w_tick_next = w_wrap;
          end
        end
        B_HI: begin
          if (!r_ph) begin
            w_ph_next = 1'b1;
          end else begin
            w_ph_next    = 1'b0;
            w_state_next = B_LO;
            w_plso_next  = 1'b0;
          end
        end
        B_LO: begin
          if (!r_ph) begin
            w_ph_next = 1'b1;
          end else begin
            w_ph_next = 1'b0;
            if (r_n == 7'd1) begin
              w_state_next = RUN;
              w_n_next     = 7'd0;
              w_cnt_next   = 16'd0;
              w_plso_next  = 1'b0;
              w_busy_next  = 1'b0;
            end else begin
              w_n_next     = r_n - 7'd1;
              w_state_next = B_HI;
              w_plso_next  = 1'b1;
            end
          end
        end
        default: w_state_next = RUN;
      endcase
`else
      if (en) begin
        w_cnt_next  = w_cnt_inc;
        w_plso_next = (w_cnt_inc >= (w_dq >> 1));
        w_tick_next = w_wrap;
      end
`endif
    end
  end

  assign plso = r_plso;
  assign tick = r_tick;

endmodule

// File: tb/tb_pls_gen.sv
// tb_pls_gen: directed stimulus with an expected-output queue checked by a
// negedge monitor; burst scenarios run when PLS_GEN_BURST_EN is defined.
module tb_pls_gen;
  logic        rst, clk, clr, en, bst_req;
  logic [15:0] div;
  logic [6:0]  bst_num;
  logic        plso, tick, bst_busy;

  logic [2:0] exp_q[$];
  string      name_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         pos;
  int         per;
  logic [2:0] mon_e;
  string      mon_nm;

  pls_gen dut (
    .rst(rst), .clk(clk), .clr(clr), .en(en), .div(div),
    .bst_req(bst_req), .bst_num(bst_num),
    .plso(plso), .tick(tick), .bst_busy(bst_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e  = exp_q.pop_front();
      mon_nm = name_q.pop_front();
      n_cmp++;
      if ({plso, tick, bst_busy} !== mon_e) begin
        n_bad++;
        $display("FAIL %s: plso/tick/busy got %b required %b", mon_nm, {plso, tick, bst_busy}, mon_e);
      end else begin
        $display("ok   %s: plso/tick/busy = %b", mon_nm, mon_e);
      end
    end
  end

  task automatic expect_now(input string nm, input logic p, input logic t, input logic b);
    exp_q.push_back({p, t, b});
    name_q.push_back(nm);
  endtask

  // One clock; optionally queue the outputs expected after that edge.
  task automatic step(input string nm, input bit chk, input logic p, input logic t, input logic b);
    @(posedge clk);
    #1;
    if (chk) expect_now(nm, p, t, b);
  endtask

  // Free-run: position advances 1..per-1,0; high for the upper half, tick at 0.
  task automatic fr(input string nm, input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      pos = (pos + 1) % per;
      step(nm, 1'b1, pos >= per / 2, pos == 0, 1'b0);
    end
  endtask

  task automatic hold(input string nm, input int ncyc);
    for (int i = 0; i < ncyc; i++) step(nm, 1'b1, pos >= per / 2, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; en = 1'b1; div = 16'd10;
    bst_req = 1'b0; bst_num = 7'd0;
    pos = 0; per = 10;
    step("reset", 1'b1, 1'b0, 1'b0, 1'b0);
    step("reset", 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;

    fr("freerun_div10", 23);
    en = 1'b0;
    hold("en_hold", 7);
    en = 1'b1;
    fr("en_resume", 12);

    div = 16'd4;
    fr("div_10to4_tail", 5);
    per = 4;
    fr("div4", 12);
    div = 16'd0; per = 2;
    fr("div0", 6);
    div = 16'd1;
    fr("div1", 6);
    div = 16'd10; per = 10;
    fr("div10_again", 7);

    clr = 1'b1;
    fr("clr_lead", 1);
    step("clr", 1'b1, 1'b0, 1'b0, 1'b0);
    pos = 0; clr = 1'b0;
    fr("after_clr", 12);

`ifdef PLS_GEN_BURST_EN
    bst_num = 7'd3; bst_req = 1'b1;
    fr("bst_lead", 1);
    for (int k = 0; k < 12; k++) begin
      step("burst3", 1'b1, (k % 4) < 2, 1'b0, 1'b1);
      if (k == 0) bst_req = 1'b0;
      if (k == 3) bst_req = 1'b1;
      if (k == 7) bst_req = 1'b0;
    end
    step("burst3_end", 1'b1, 1'b0, 1'b0, 1'b0);
    pos = 0;
    fr("after_burst", 11);

    bst_num = 7'd0; bst_req = 1'b1;
    fr("bst_num0_ignored", 6);
    bst_req = 1'b0;
    fr("bst_num0_ignored", 2);

    bst_num = 7'd5; bst_req = 1'b1;
    fr("abort_lead", 1);
    for (int k = 0; k < 4; k++) begin
      step("burst5", 1'b1, k < 2, 1'b0, 1'b1);
      if (k == 0) bst_req = 1'b0;
    end
    clr = 1'b1;
    step("burst5_pre_clr", 1'b1, 1'b1, 1'b0, 1'b1);
    step("abort_clr", 1'b1, 1'b0, 1'b0, 1'b0);
    pos = 0; clr = 1'b0;
    fr("after_abort", 8);

    bst_num = 7'd2; clr = 1'b1; bst_req = 1'b1;
    fr("both_lead", 1);
    step("both_clr_wins", 1'b1, 1'b0, 1'b0, 1'b0);
    pos = 0; clr = 1'b0; bst_req = 1'b0;
    fr("after_both", 6);

    bst_num = 7'd4; bst_req = 1'b1;
    fr("rst_lead", 1);
    step("rst_burst", 1'b1, 1'b1, 1'b0, 1'b1);
    step("", 1'b0, 1'b0, 1'b0, 1'b0);
`else
    bst_num = 7'd3; bst_req = 1'b1;
    fr("nobst_toggle", 3);
    bst_req = 1'b0;
    fr("nobst_toggle", 2);
    bst_req = 1'b1;
    fr("nobst_toggle", 6);
    fr("nobst_run", 2);
    pos = (pos + 1) % per;
    step("", 1'b0, 1'b0, 1'b0, 1'b0);
`endif
    // Reset lands between edges; clr and bst_req stay high across its release.
    rst = 1'b0; clr = 1'b1; bst_req = 1'b1;
    expect_now("rst_async", 1'b0, 1'b0, 1'b0);
    step("rst_hold", 1'b1, 1'b0, 1'b0, 1'b0);
    step("rst_hold", 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1; pos = 0; per = 10;
    fr("rst_release_inputs_high", 14);
    clr = 1'b0; bst_req = 1'b0;
    fr("after_release", 4);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
